// File: rtl/if_stage.sv
// Instruction fetch for the RV32I pipeline: PC register, single-outstanding imem handshake, IF/ID register.
// Latency: one IF/ID load per cycle with a next-cycle rvalid memory. Stall holds PC and IF/ID; redirect flushes.
// Optional IF_PERF_COUNT_EN adds perf_fetched/perf_bubbles counters of IF/ID loads.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        ifid_valid,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_instr
`ifdef IF_PERF_COUNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_bubbles
`endif
);

    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD, S_KILL} state_t;

    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_q, hold_d;
    logic        ifid_valid_q;
    logic [31:0] ifid_pc_q;
    logic [31:0] ifid_instr_q;

    logic        req;
    logic [31:0] addr;
    logic [31:0] pc_inc;
    logic        ld;
    logic        ld_valid;
    logic [31:0] ld_pc;
    logic [31:0] ld_instr;

    assign pc_inc = pc_q + 32'd4;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        hold_d   = hold_q;
        req      = 1'b0;
        addr     = pc_q;
        ld       = 1'b0;
        ld_valid = 1'b0;
        ld_pc    = ifid_pc_q;
        ld_instr = NOP_INSTR;

        if (redirect_i) begin
            // A response still owed to a WAIT/KILL must be swallowed before refetching.
            pc_d    = redirect_pc_i & ALIGN_MASK;
            ld      = 1'b1;
            state_d = ((state_q == S_WAIT || state_q == S_KILL) && !imem_rvalid) ? S_KILL : S_FETCH;
        end else begin
            case (state_q)
                S_FETCH: begin
                    req = 1'b1;
                    ld  = !stall_i;
                    if (imem_ready) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid && !stall_i) begin
                        ld       = 1'b1;
                        ld_valid = 1'b1;
                        ld_pc    = pc_q;
                        ld_instr = imem_rdata;
                        pc_d     = pc_inc;
                        req      = 1'b1;
                        addr     = pc_inc;
                        state_d  = imem_ready ? S_WAIT : S_FETCH;
                    end else if (imem_rvalid) begin
                        hold_d  = imem_rdata;
                        state_d = S_HOLD;
                    end else begin
                        ld = !stall_i;
                    end
                end
                S_HOLD: begin
                    if (!stall_i) begin
                        ld       = 1'b1;
                        ld_valid = 1'b1;
                        ld_pc    = pc_q;
                        ld_instr = hold_q;
                        pc_d     = pc_inc;
                        state_d  = S_FETCH;
                    end
                end
                S_KILL: begin
                    ld = !stall_i;
                    if (imem_rvalid) begin
                        state_d = S_FETCH;
                    end
                end
                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC & ALIGN_MASK;
            hold_q       <= '0;
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= '0;
            ifid_instr_q <= NOP_INSTR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hold_q  <= hold_d;
            if (ld) begin
                ifid_valid_q <= ld_valid;
                ifid_pc_q    <= ld_pc;
                ifid_instr_q <= ld_instr;
            end
        end
    end

    // Gated so the first request appears only once reset has been released.
    assign imem_req   = req & reset_n;
    assign imem_addr  = addr & ALIGN_MASK;
    assign ifid_valid = ifid_valid_q;
    assign ifid_pc    = ifid_pc_q;
    assign ifid_instr = ifid_instr_q;

`ifdef IF_PERF_COUNT_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_bubbles_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_fetched_q <= '0;
            perf_bubbles_q <= '0;
        end else if (ld) begin
            if (ld_valid) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end else begin
                perf_bubbles_q <= perf_bubbles_q + 32'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_bubbles = perf_bubbles_q;
`endif

endmodule
